fetch_arbiter_ctrl: RTL and testbench
=====================================

FETCH_ARBITER_CTRL -- requirements
Module: fetch_arbiter_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: cycles reset_addr_counter is held per transaction (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in WAIT (16-bit).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  3  level requests; bit0 weight, bit1 bias, bit2 input buffer.
REQ-006 SHALL have port tiles_ctrl  input  3  per-requester tiling mode; 1 = tiling 32, 0 = tiling 512.
REQ-007 SHALL have port grant  output  3  one-hot owner of the fetch unit, 0 when idle.
REQ-008 SHALL have port done  output  3  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port Buffer_Select  output  3  to fetch unit; 3'b000 weight, 3'b001 bias, 3'b010 input.
REQ-010 SHALL have port Tiles_Control  output  1  to fetch unit.
REQ-011 SHALL have port reset_addr_counter  output  1  to fetch unit.
REQ-012 SHALL have port start_fetch  output  1  one-cycle pulse to fetch unit.
REQ-013 SHALL have port fetch_done  input  1  completion level from fetch unit.
REQ-014 SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, START, WAIT, DONE; all outputs registered.
REQ-016 IDLE: if req != 0, SHALL select winner round-robin starting at rr_ptr, register grant, Buffer_Select and Tiles_Control = tiles_ctrl[winner], go CLR next cycle; else stay.
REQ-017 CLR: reset_addr_counter = 1 for exactly RST_CYCLES cycles, then START.
REQ-018 START: start_fetch = 1 for exactly one cycle, then WAIT.
REQ-019 WAIT: SHALL exit to DONE on first sampled fetch_done = 1; fetch_done outside WAIT ignored.
REQ-020 DONE: done[winner] = 1 one cycle; grant cleared; rr_ptr = (winner+1) mod 3; return IDLE.
REQ-021 Grant-to-start latency SHALL be RST_CYCLES+1 cycles after the IDLE decision edge.
REQ-022 Buffer_Select and Tiles_Control SHALL stay stable from CLR through DONE; they keep last values in IDLE.
REQ-023 req deassertion after grant SHALL NOT abort the transaction; done still pulses.
REQ-024 Requester still asserting req after its done SHALL be served after all other pending requesters (round-robin fairness).
REQ-025 Simultaneous requests: lowest index at or after rr_ptr wins; rr_ptr resets to 0 (weight first).
REQ-026 tiles_ctrl changes after grant SHALL have no effect until the next grant.
REQ-027 At most one of grant bits, and at most one of done bits, SHALL be high in any cycle.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, grant 0, done 0, Buffer_Select 3'b000, Tiles_Control 0, reset_addr_counter 0, start_fetch 0, timeout_err 0, rr_ptr 0, counters 0.
REQ-029 Reset mid-transaction SHALL abandon it without done pulse; requester re-requests after reset.

Configuration
REQ-030 With macro FETCH_TIMEOUT_EN defined: WAIT cycle counter; reaching TIMEOUT_CYCLES without fetch_done SHALL set timeout_err and go DONE (done still pulses); timeout_err clears at next IDLE grant.
REQ-031 Without FETCH_TIMEOUT_EN: no counter, WAIT waits indefinitely, timeout_err tied 0.

Verification
REQ-032 Reset release, req=3'b001, tiles_ctrl=3'b001 -> grant=001, Buffer_Select=000, Tiles_Control=1, reset_addr_counter high 2 cycles, start_fetch 1 cycle, done[0] one cycle after fetch_done.
REQ-033 req=3'b111 held throughout -> grant order 001, 010, 100, 001; Buffer_Select 000, 001, 010, 000.
REQ-034 Grant to input (req=3'b100, tiles_ctrl[2]=0), toggle tiles_ctrl and drop req in WAIT -> Tiles_Control stays 0, done[2] still pulses.
REQ-035 fetch_done held high in IDLE/CLR/START -> ignored until WAIT; exit one cycle after entering WAIT.
REQ-036 rst_n low during WAIT -> all outputs zero same cycle, no done; after release req=3'b010 served normally.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, fetch_done never high -> timeout_err=1 after 16 WAIT cycles, done pulses, cleared at next grant.

Source files
------------

// File: rtl/fetch_arbiter_ctrl.sv
// Round-robin arbiter that hands the shared fetch unit to weight, bias or input-buffer requesters.
// Optional WAIT watchdog is compiled in with `define FETCH_TIMEOUT_EN.
module fetch_arbiter_ctrl #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] tiles_ctrl,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [2:0] Buffer_Select,
  output logic       Tiles_Control,
  output logic       reset_addr_counter,
  output logic       start_fetch,
  input  logic       fetch_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CLR_LAST = 4'(RST_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] clr_cnt;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic [1:0] pick;
  logic       wait_expired;
  logic       take_grant;

  logic [2:0] grant_d;
  logic [2:0] done_d;
  logic [2:0] buf_sel_d;
  logic       tiles_d;
  logic       rac_d;
  logic       start_d;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign take_grant = (state == IDLE) && (req != 3'b000);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req != 3'b000) next_state = CLR;
      CLR:     if (clr_cnt == CLR_LAST) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (fetch_done || wait_expired) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Rotating priority: first asserted requester at or after rr_ptr.
  always_comb begin
    case (rr_ptr)
      2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Strobes follow the state one cycle later, which yields the RST_CYCLES+1 grant-to-start latency.
  always_comb begin
    grant_d   = grant;
    buf_sel_d = Buffer_Select;
    tiles_d   = Tiles_Control;
    done_d    = 3'b000;
    rac_d     = (state == CLR);
    start_d   = (state == START);
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          grant_d   = onehot(pick);
          buf_sel_d = {1'b0, pick};
          tiles_d   = tiles_ctrl[pick];
        end
      end
      DONE: begin
        grant_d = 3'b000;
        done_d  = onehot(winner);
      end
      default: ;
    endcase
  end

  // NOTE: every register here is control state, so all of them take the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant              <= 3'b000;
      done               <= 3'b000;
      Buffer_Select      <= 3'b000;
      Tiles_Control      <= 1'b0;
      reset_addr_counter <= 1'b0;
      start_fetch        <= 1'b0;
      winner             <= 2'd0;
      rr_ptr             <= 2'd0;
      clr_cnt            <= 4'd0;
    end else begin
      grant              <= grant_d;
      done               <= done_d;
      Buffer_Select      <= buf_sel_d;
      Tiles_Control      <= tiles_d;
      reset_addr_counter <= rac_d;
      start_fetch        <= start_d;
      clr_cnt            <= (state == CLR) ? clr_cnt + 4'd1 : 4'd0;
      if (take_grant) begin
        winner <= pick;
      end
      if (state == DONE) begin
        rr_ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;

  assign wait_expired = (state == WAIT) && !fetch_done && (wait_cnt == WAIT_LAST);

  // The flag stays set through DONE and IDLE so software can see it until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : 16'd0;
      if (wait_expired) begin
        timeout_err <= 1'b1;
      end else if (take_grant) begin
        timeout_err <= 1'b0;
      end
    end
  end
`else
  assign wait_expired = 1'b0;

  // Without the watchdog TIMEOUT_CYCLES has no effect; legal values are always non-zero.
  if (TIMEOUT_CYCLES != 0) begin : g_no_watchdog
    assign timeout_err = 1'b0;
  end
`endif

endmodule

// File: tb/tb_fetch_arbiter_ctrl.sv
// Self-checking bench for fetch_arbiter_ctrl: directed scenarios plus random traffic,
// all scored against a transaction-timeline model of the arbiter.
module tb_fetch_arbiter_ctrl;

  localparam int RST = 2;
  localparam int TMO = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] tiles_ctrl = 3'b000;
  logic       fetch_done = 1'b0;
  logic [2:0] grant;
  logic [2:0] done;
  logic [2:0] Buffer_Select;
  logic       Tiles_Control;
  logic       reset_addr_counter;
  logic       start_fetch;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // Model: m_t counts edges since the grant decision (-1 = idle), m_end is the edge WAIT was left.
  int         m_t, m_end, m_w, m_rr;
  logic [2:0] e_grant, e_done, e_bs;
  logic       e_tc, e_rac, e_start, e_to;

  fetch_arbiter_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tiles_ctrl(tiles_ctrl),
    .grant(grant), .done(done), .Buffer_Select(Buffer_Select),
    .Tiles_Control(Tiles_Control), .reset_addr_counter(reset_addr_counter),
    .start_fetch(start_fetch), .fetch_done(fetch_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [12:0] obs_vec();
    return {grant, done, Buffer_Select, Tiles_Control, reset_addr_counter, start_fetch, timeout_err};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {e_grant, e_done, e_bs, e_tc, e_rac, e_start, e_to};
  endfunction

  task automatic model_reset();
    m_t = -1; m_end = -1; m_w = 0; m_rr = 0;
    e_grant = 3'b000; e_done = 3'b000; e_bs = 3'b000;
    e_tc = 1'b0; e_rac = 1'b0; e_start = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic [2:0] t, input logic fd);
    bit found;
    e_done = 3'b000; e_rac = 1'b0; e_start = 1'b0;
    if (m_t < 0) begin
      if (r != 3'b000) begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (m_rr + k) % 3;
          if (!found && r[idx]) begin
            found = 1'b1;
            m_w = idx;
          end
        end
        e_grant = 3'(1 << m_w);
        e_bs = 3'(m_w);
        e_tc = t[m_w];
        e_to = 1'b0;
        m_t = 0;
        m_end = -1;
      end
    end else begin
      m_t++;
      if (m_end >= 0 && m_t == m_end + 1) begin
        e_done = 3'(1 << m_w);
        e_grant = 3'b000;
        m_rr = (m_w + 1) % 3;
        m_t = -1;
        m_end = -1;
      end else if (m_t <= RST) begin
        e_rac = 1'b1;
      end else if (m_t == RST + 1) begin
        e_start = 1'b1;
      end else if (m_end < 0) begin
        if (fd) begin
          m_end = m_t;
        end else if (TO_EN && (m_t - (RST + 1) == TMO)) begin
          m_end = m_t;
          e_to = 1'b1;
        end
      end
    end
  endtask

  // One clock: DUT and model both advance on the rising edge, outputs are then read at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(req, tiles_ctrl, fetch_done);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 3'b000; tiles_ctrl = 3'b000; fetch_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    if (obs_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async: outputs %b, expected all zero", obs_vec());
    end
    vectors++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_single();
    int rac_n, start_n, done_at;
    apply_reset();
    rac_n = 0; start_n = 0; done_at = -1;
    req = 3'b001; tiles_ctrl = 3'b001;
    tick();
    if ({grant, Buffer_Select, Tiles_Control} !== {3'b001, 3'b000, 1'b1}) begin
      miscompares++;
      $display("FAIL single_grant: grant/bs/tc %b, expected 001_000_1", {grant, Buffer_Select, Tiles_Control});
    end
    vectors++;
    req = 3'b000;
    for (int i = 1; i < 12; i++) begin
      fetch_done = (i == RST + 2);
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      rac_n += int'(reset_addr_counter);
      start_n += int'(start_fetch);
      if (done == 3'b001) done_at = i;
    end
    fetch_done = 1'b0;
    if ({rac_n, start_n, done_at} !== {RST, 1, RST + 3}) begin
      miscompares++;
      $display("FAIL single_timing: rac=%0d start=%0d done_at=%0d, expected %0d 1 %0d",
               rac_n, start_n, done_at, RST, RST + 3);
    end
    vectors++;
  endtask

  task automatic test_round_robin();
    logic [2:0] want_g [4];
    logic [2:0] want_b [4];
    logic [2:0] q_g [$];
    logic [2:0] q_b [$];
    logic [2:0] prev, got_g, got_b;
    apply_reset();
    want_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    want_b = '{3'b000, 3'b001, 3'b010, 3'b000};
    req = 3'b111; fetch_done = 1'b1; tiles_ctrl = 3'($urandom_range(0, 7));
    prev = 3'b000;
    for (int i = 0; i < 4 * (RST + 4); i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (prev == 3'b000 && grant != 3'b000) begin
        q_g.push_back(grant);
        q_b.push_back(Buffer_Select);
      end
      prev = grant;
    end
    for (int k = 0; k < 4; k++) begin
      got_g = (k < q_g.size()) ? q_g[k] : 3'bxxx;
      got_b = (k < q_b.size()) ? q_b[k] : 3'bxxx;
      if ({got_g, got_b} !== {want_g[k], want_b[k]}) begin
        miscompares++;
        $display("FAIL rr_order #%0d: grant/bs %b/%b, expected %b/%b", k, got_g, got_b, want_g[k], want_b[k]);
      end
      vectors++;
    end
    req = 3'b000; fetch_done = 1'b0;
  endtask

  task automatic test_tiles_hold();
    int done_at;
    apply_reset();
    done_at = -1;
    req = 3'b100; tiles_ctrl = 3'b000;
    tick();
    for (int i = 1; i < RST + 8; i++) begin
      if (i == RST + 2) begin
        tiles_ctrl = 3'b111;
        req = 3'b000;
      end
      fetch_done = (i == RST + 4);
      tick();
      if (obs_vec() !== exp_vec() || Tiles_Control !== 1'b0) begin
        miscompares++;
        $display("FAIL tiles_hold cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (done == 3'b100) done_at = i;
    end
    if (done_at !== RST + 5) begin
      miscompares++;
      $display("FAIL tiles_hold_done: done[2] at %0d, expected %0d", done_at, RST + 5);
    end
    vectors++;
    tiles_ctrl = 3'b000; fetch_done = 1'b0;
  endtask

  task automatic test_fetch_done_early();
    int start_at, done_at;
    apply_reset();
    start_at = -1; done_at = -1;
    fetch_done = 1'b1;
    repeat (3) tick();
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 1; i < RST + 6; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL early_fd cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (start_fetch) start_at = i;
      if (done == 3'b001) done_at = i;
    end
    if ({start_at, done_at} !== {RST + 1, RST + 3}) begin
      miscompares++;
      $display("FAIL early_fd_timing: start_at=%0d done_at=%0d, expected %0d %0d",
               start_at, done_at, RST + 1, RST + 3);
    end
    vectors++;
    fetch_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    apply_reset();
    done_seen = 0;
    req = 3'b010;
    tick();
    for (int i = 1; i <= RST + 2; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    if (obs_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid: outputs %b, expected all zero", obs_vec());
    end
    vectors++;
    @(negedge clk);
    if (obs_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: outputs %b, expected all zero", obs_vec());
    end
    vectors++;
    rst_n = 1'b1;
    tick();
    if (grant !== 3'b010 || Buffer_Select !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_mid_regrant: grant/bs %b/%b, expected 010/001", grant, Buffer_Select);
    end
    vectors++;
    req = 3'b000;
    for (int i = 1; i < RST + 6; i++) begin
      fetch_done = (i == RST + 2);
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_serve cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (done == 3'b010) done_seen++;
    end
    if (done_seen !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_done: done[1] pulses %0d, expected 1", done_seen);
    end
    vectors++;
    fetch_done = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req = 3'($urandom_range(0, 7));
      tiles_ctrl = 3'($urandom_range(0, 7));
      fetch_done = ($urandom_range(0, 3) == 0);
      tick();
      if (obs_vec() !== exp_vec() || $countones(grant) > 1 || $countones(done) > 1) begin
        miscompares++;
        $display("FAIL random cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
    end
    req = 3'b000; fetch_done = 1'b0;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int to_at, done_at;
    apply_reset();
    to_at = -1; done_at = -1;
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 1; i < RST + TMO + 6; i++) begin
      if (i == RST + TMO + 3) req = 3'b010;
      tick();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL timeout cyc%0d: outputs %b, expected %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (timeout_err && to_at < 0) to_at = i;
      if (done == 3'b001) done_at = i;
    end
    if ({to_at, done_at} !== {RST + 1 + TMO, RST + 2 + TMO} || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_timing: to_at=%0d done_at=%0d err_now=%b, expected %0d %0d 0",
               to_at, done_at, timeout_err, RST + 1 + TMO, RST + 2 + TMO);
    end
    vectors++;
    req = 3'b000;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_tiles_hold();
    test_fetch_done_early();
    test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
